// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one word fetch at a time, hands the word to the
// consumer, and handles jump/branch redirects, halt, and squashing of in-flight fetches.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        busy
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pending;
  logic              redirect;
  logic [XLEN-1:0]   target;

  // Jump wins over branch; branch offsets are relative to the word after the branch.
  always_comb begin
    redirect = jump | branch;
    target   = jump ? redirect_target
                    : redirect_base + XLEN'(1) + redirect_target;
  end

  // Request and busy decode straight from the state register, so memory inputs never
  // reach an output combinationally.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign busy      = imem_req;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pending     <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= halt ? HALTED : FETCH;

        FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              pc <= target;
            end else begin
              instr       <= imem_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + XLEN'(1);
              state       <= ISSUE;
            end
          end else if (redirect) begin
            pending <= target;
            state   <= DRAIN;
          end
        end

        // The outstanding request keeps its address; its response is thrown away.
        DRAIN: begin
          if (imem_ready) begin
            pc    <= redirect ? target : pending;
            state <= FETCH;
          end else if (redirect) begin
            pending <= target;
          end
        end

        ISSUE: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= target;
            state       <= halt ? HALTED : FETCH;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            state       <= halt ? HALTED : FETCH;
          end
        end

        HALTED: begin
          if (redirect) pc <= target;
          if (!halt) state <= FETCH;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low; 0 = reset, sampled on posedge clk.
REQ-004 imem_req  output  1  instruction memory request; held high until imem_ready.
REQ-005 imem_addr  output  32  word address of current request; equals pc while imem_req=1.
REQ-006 imem_ready  input  1  memory response strobe; imem_data valid the same cycle.
REQ-007 imem_data  input  32  instruction word from memory.
REQ-008 instr_valid  output  1  instr/instr_pc hold a fetched, unsquashed instruction.
REQ-009 instr  output  32  fetched instruction word.
REQ-010 instr_pc  output  32  word address instr was fetched from.
REQ-011 stall  input  1  consumer not accepting; instruction is accepted when instr_valid=1 and stall=0.
REQ-012 jump  input  1  absolute redirect request.
REQ-013 branch  input  1  relative redirect request.
REQ-014 redirect_base  input  32  PC of the branch instruction.
REQ-015 redirect_target  input  32  jump: absolute address; branch: signed word offset.
REQ-016 halt  input  1  stop issuing new fetches.
REQ-017 busy  output  1  high in FETCH or DRAIN.

Function
REQ-018 States: IDLE, FETCH, ISSUE, DRAIN, HALTED; binary encoded; one state register.
REQ-019 PC arithmetic modulo 2^32; sequential next = pc+1 (word addressing); jump target = redirect_target; branch target = redirect_base + 1 + redirect_target.
REQ-020 jump has priority over branch when both high; redirect = jump|branch.
REQ-021 IDLE: imem_req=0; next cycle -> HALTED if halt=1, else FETCH.
REQ-022 FETCH: imem_req=1, imem_addr=pc; on imem_ready with no redirect: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1, -> ISSUE.
REQ-023 FETCH with redirect and imem_ready same cycle: data discarded, instr_valid stays 0, pc<=target, remain FETCH (new request next cycle).
REQ-024 FETCH with redirect and imem_ready=0: target latched into pending register, pc and imem_addr unchanged, -> DRAIN.
REQ-025 DRAIN: imem_req=1 with original address; further redirects overwrite pending (latest wins); on imem_ready data discarded, pc<=pending (or the same-cycle redirect target if one is present), -> FETCH.
REQ-026 ISSUE: instr_valid=1, outputs stable while stall=1; when stall=0: instr_valid<=0, -> HALTED if halt=1 else FETCH.
REQ-027 ISSUE with redirect (any stall value): instr_valid<=0 (squash), pc<=target, -> FETCH (HALTED if halt=1).
REQ-028 HALTED: imem_req=0; redirect updates pc, stays HALTED; halt=0 -> FETCH next cycle.
REQ-029 halt is ignored in FETCH/DRAIN; an outstanding request always completes first.
REQ-030 Throughput: at most one instruction per 2 cycles with zero-latency memory (FETCH, ISSUE).
REQ-031 No combinational path from imem_ready/imem_data to any output; all outputs registered or decoded from state/pc.

Reset
REQ-032 reset=0 at posedge clk: state<=IDLE, pc<=RESET_PC, pending<=0, instr<=0, instr_pc<=0, instr_valid<=0; imem_req=0, busy=0.
REQ-033 reset overrides all inputs, including mid-request in FETCH/DRAIN; a later imem_ready for the abandoned request is not captured unless it arrives while in FETCH.

Verification
REQ-034 Reset release, imem_ready tied 1, stall=0: imem_addr 0,1,2,3 on alternate cycles; instr_pc 0,1,2,... with matching instr.
REQ-035 FETCH addr 5, jump=1, target 0x40, imem_ready=0 for 3 cycles: imem_addr held 5; response discarded; next request addr 0x40; instr_valid never set for addr 5.
REQ-036 ISSUE instr_pc=8, stall=1 for 4 cycles, then branch with base 8, offset -3: instr squashed; next fetch addr 6.
REQ-037 pc=32'hFFFF_FFFF fetched: next sequential fetch addr 0; branch base 0xFFFF_FFFF offset 0: target 0.
REQ-038 halt=1 in ISSUE, stall=0: -> HALTED, imem_req=0; jump to 0x100 while halted; halt=0: next fetch addr 0x100.
REQ-039 reset=0 asserted in DRAIN: next cycle state IDLE, pc=RESET_PC, instr_valid=0, imem_req=0.
